// File: rtl/uart_word_tx.sv
// uart_word_tx: serialises one WORD_BYTES-byte word as back-to-back UART frames
//   (start, DATA_BITS LSB-first, optional parity, STOP_BITS stop).
// Latency: start bit is driven on txd one clock after tx_start is seen in idle.
// Backpressure: tx_start is ignored while busy. If tx_start is high on the
//   completion edge, the next word starts at that edge with no idle gap.
// Ports:
//   clk, rst        - clock; asynchronous active-high reset
//   tx_start        - request; honoured when idle or on the completion edge
//   tx_data         - word to send, latched on the accept edge
//   tx_busy         - high from the accept edge until the word completes
//   tx_done         - one-cycle pulse when the last stop bit ends
//   txd             - registered serial line, idle high
module uart_word_tx #(
  parameter int CLK_DIV        = 434,
  parameter int DATA_BITS      = 8,
  parameter int WORD_BYTES     = 4,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 2,
  parameter int MSB_BYTE_FIRST = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            tx_start,
  input  logic [WORD_BYTES*DATA_BITS-1:0] tx_data,
  output logic                            tx_busy,
  output logic                            tx_done,
  output logic                            txd
);

  localparam int WORD_W = WORD_BYTES * DATA_BITS;
  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BYTE_W = $clog2(WORD_BYTES) + 1;

  localparam logic [DIV_W-1:0]  DIV_LOAD  = DIV_W'(CLK_DIV - 1);
  localparam logic [2:0]        LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]        LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(WORD_BYTES - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t                 state;
  logic [DIV_W-1:0]       div_cnt;
  logic [2:0]             bit_cnt;
  logic [BYTE_W-1:0]      byte_cnt;
  logic [WORD_W-1:0]      word_q;
  logic [DATA_BITS-1:0]   shreg;

  logic [BYTE_W-1:0]      byte_idx;
  logic [DATA_BITS-1:0]   cur_byte;
  logic                   par_bit;

  // byte_cnt always counts up; the physical byte index is mirrored for
  // MSB-first ordering.
  always_comb begin
    byte_idx = (MSB_BYTE_FIRST != 0) ? (LAST_BYTE - byte_cnt) : byte_cnt;
    cur_byte = '0;
    for (int b = 0; b < WORD_BYTES; b++) begin
      if (byte_idx == BYTE_W'(b)) begin
        cur_byte = word_q[b*DATA_BITS +: DATA_BITS];
      end
    end
    // Even parity is the plain XOR; odd parity inverts it.
    par_bit = (^cur_byte) ^ (PARITY == 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      word_q   <= '0;
      shreg    <= '0;
      txd      <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (state == IDLE) begin
        txd <= 1'b1;
        if (tx_start) begin
          word_q   <= tx_data;
          byte_cnt <= '0;
          bit_cnt  <= '0;
          div_cnt  <= DIV_LOAD;
          txd      <= 1'b0;
          tx_busy  <= 1'b1;
          state    <= START;
        end
      end else if (div_cnt != '0) begin
        div_cnt <= div_cnt - 1'b1;
      end else begin
        // Bit boundary: reload the divider and move to the next bit.
        div_cnt <= DIV_LOAD;
        case (state)
          START: begin
            txd     <= cur_byte[0];
            shreg   <= cur_byte >> 1;
            bit_cnt <= '0;
            state   <= DATA;
          end
          DATA: begin
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              if (PARITY != 0) begin
                txd   <= par_bit;
                state <= PAR;
              end else begin
                txd   <= 1'b1;
                state <= STOP;
              end
            end else begin
              txd     <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          PAR: begin
            txd     <= 1'b1;
            bit_cnt <= '0;
            state   <= STOP;
          end
          STOP: begin
            if (bit_cnt != LAST_STOP) begin
              bit_cnt <= bit_cnt + 3'd1;
            end else if (byte_cnt != LAST_BYTE) begin
              byte_cnt <= byte_cnt + 1'b1;
              txd      <= 1'b0;
              state    <= START;
            end else begin
              tx_done <= 1'b1;
              if (tx_start) begin
                // Chain straight into the next word: start bit follows
                // the last stop bit with no idle cycle.
                word_q   <= tx_data;
                byte_cnt <= '0;
                bit_cnt  <= '0;
                txd      <= 1'b0;
                state    <= START;
              end else begin
                txd     <= 1'b1;
                tx_busy <= 1'b0;
                state   <= IDLE;
              end
            end
          end
          default: begin
            txd     <= 1'b1;
            tx_busy <= 1'b0;
            state   <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: several parameterisations driven with fixed and
// $urandom words; txd/tx_busy/tx_done are compared every clock against a
// bit-stream built from the frame rules.
module tb_uart_word_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic s0 = 0, s1 = 0, s2 = 0, s3 = 0, s4 = 0;
  logic [31:0] d0 = '0, d3 = '0;
  logic [7:0]  d1 = '0, d2 = '0;
  logic [14:0] d4 = '0;
  logic b0, b1, b2, b3, b4;
  logic dn0, dn1, dn2, dn3, dn4;
  logic t0, t1, t2, t3, t4;

  int checks = 0;
  int errors = 0;
  bit exp_bits[$];

  // u0: main 4-byte 8N2, CLK_DIV=4
  uart_word_tx #(.CLK_DIV(4), .DATA_BITS(8), .WORD_BYTES(4), .PARITY(0), .STOP_BITS(2), .MSB_BYTE_FIRST(0))
    u0 (.clk(clk), .rst(rst), .tx_start(s0), .tx_data(d0), .tx_busy(b0), .tx_done(dn0), .txd(t0));
  // u1: even parity, 1 byte, 1 stop
  uart_word_tx #(.CLK_DIV(3), .DATA_BITS(8), .WORD_BYTES(1), .PARITY(2), .STOP_BITS(1), .MSB_BYTE_FIRST(0))
    u1 (.clk(clk), .rst(rst), .tx_start(s1), .tx_data(d1), .tx_busy(b1), .tx_done(dn1), .txd(t1));
  // u2: odd parity, 1 byte, 1 stop
  uart_word_tx #(.CLK_DIV(3), .DATA_BITS(8), .WORD_BYTES(1), .PARITY(1), .STOP_BITS(1), .MSB_BYTE_FIRST(0))
    u2 (.clk(clk), .rst(rst), .tx_start(s2), .tx_data(d2), .tx_busy(b2), .tx_done(dn2), .txd(t2));
  // u3: MSB byte first
  uart_word_tx #(.CLK_DIV(4), .DATA_BITS(8), .WORD_BYTES(4), .PARITY(0), .STOP_BITS(2), .MSB_BYTE_FIRST(1))
    u3 (.clk(clk), .rst(rst), .tx_start(s3), .tx_data(d3), .tx_busy(b3), .tx_done(dn3), .txd(t3));
  // u4: CLK_DIV=1, 5 data bits, even parity, 3 bytes -> F=8, 24 clocks/word
  uart_word_tx #(.CLK_DIV(1), .DATA_BITS(5), .WORD_BYTES(3), .PARITY(2), .STOP_BITS(1), .MSB_BYTE_FIRST(0))
    u4 (.clk(clk), .rst(rst), .tx_start(s4), .tx_data(d4), .tx_busy(b4), .tx_done(dn4), .txd(t4));

  // Reference: append the serial bit stream of one word to exp_bits.
  task automatic model_frame(input logic [63:0] word, input int db, input int wb,
                             input int par, input int stops, input int msb);
    for (int j = 0; j < wb; j++) begin
      int bi;
      int ones;
      bi = (msb != 0) ? (wb - 1 - j) : j;
      ones = 0;
      exp_bits.push_back(1'b0);
      for (int i = 0; i < db; i++) begin
        ones += int'(word[bi*db + i]);
        exp_bits.push_back(word[bi*db + i]);
      end
      if (par == 1) exp_bits.push_back(ones % 2 == 0);
      if (par == 2) exp_bits.push_back(ones % 2 == 1);
      for (int s = 0; s < stops; s++) exp_bits.push_back(1'b1);
    end
  endtask

  task automatic test_reset();
    logic [2:0] got [5];
    rst = 1'b1;
    repeat (2) @(negedge clk);
    got = '{ {t0,b0,dn0}, {t1,b1,dn1}, {t2,b2,dn2}, {t3,b3,dn3}, {t4,b4,dn4} };
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (got[i] !== 3'b100) begin
        errors++;
        $display("FAIL reset u%0d: got {txd,busy,done}=%b expected 100", i, got[i]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({t0,b0,dn0} !== 3'b100) begin
      errors++;
      $display("FAIL idle after reset: got %b expected 100", {t0,b0,dn0});
    end
  endtask

  // Fixed word from the frame example plus random words on the LSB-first DUT.
  task automatic test_basic_words();
    for (int k = 0; k < 4; k++) begin
      logic [31:0] w;
      logic [2:0] ev;
      w = (k == 0) ? 32'h44332211 : $urandom;
      exp_bits.delete();
      model_frame({32'h0, w}, 8, 4, 0, 2, 0);
      s0 = 1'b1; d0 = w;
      @(negedge clk);
      s0 = 1'b0; d0 = $urandom;
      for (int n = 0; n <= 177; n++) begin
        ev = (n < 176) ? {exp_bits[n/4], 2'b10} : (n == 176) ? 3'b101 : 3'b100;
        checks++;
        if ({t0,b0,dn0} !== ev) begin
          errors++;
          $display("FAIL basic word %0d cycle %0d: got %b expected %b", k, n, {t0,b0,dn0}, ev);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_parity();
    for (int k = 0; k < 6; k++) begin
      int p;
      logic [7:0] w;
      logic [2:0] ev;
      logic [2:0] got;
      p = (k % 2 == 0) ? 2 : 1;
      w = (k < 2) ? 8'h07 : 8'($urandom);
      exp_bits.delete();
      if (k < 2) begin
        // 0x07: start, 1,1,1,0,0,0,0,0, parity, stop
        exp_bits = '{0,1,1,1,0,0,0,0,0,(p == 2),1};
      end else begin
        model_frame({56'h0, w}, 8, 1, p, 1, 0);
      end
      if (p == 2) begin s1 = 1'b1; d1 = w; end
      else        begin s2 = 1'b1; d2 = w; end
      @(negedge clk);
      s1 = 1'b0; s2 = 1'b0;
      for (int n = 0; n <= 34; n++) begin
        got = (p == 2) ? {t1,b1,dn1} : {t2,b2,dn2};
        ev = (n < 33) ? {exp_bits[n/3], 2'b10} : (n == 33) ? 3'b101 : 3'b100;
        checks++;
        if (got !== ev) begin
          errors++;
          $display("FAIL parity p=%0d data %h cycle %0d: got %b expected %b", p, w, n, got, ev);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_msb_first();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] w;
      logic [2:0] ev;
      w = (k == 0) ? 32'h44332211 : $urandom;
      exp_bits.delete();
      model_frame({32'h0, w}, 8, 4, 0, 2, 1);
      s3 = 1'b1; d3 = w;
      @(negedge clk);
      s3 = 1'b0;
      for (int n = 0; n <= 177; n++) begin
        ev = (n < 176) ? {exp_bits[n/4], 2'b10} : (n == 176) ? 3'b101 : 3'b100;
        checks++;
        if ({t3,b3,dn3} !== ev) begin
          errors++;
          $display("FAIL msb first %h cycle %0d: got %b expected %b", w, n, {t3,b3,dn3}, ev);
        end
        @(negedge clk);
      end
    end
  endtask

  // A second request and data changes mid-word must not disturb the output.
  task automatic test_ignore_busy();
    logic [31:0] w;
    logic [2:0] ev;
    w = $urandom;
    exp_bits.delete();
    model_frame({32'h0, w}, 8, 4, 0, 2, 0);
    s0 = 1'b1; d0 = w;
    @(negedge clk);
    s0 = 1'b0;
    for (int n = 0; n <= 177; n++) begin
      ev = (n < 176) ? {exp_bits[n/4], 2'b10} : (n == 176) ? 3'b101 : 3'b100;
      checks++;
      if ({t0,b0,dn0} !== ev) begin
        errors++;
        $display("FAIL ignore busy cycle %0d: got %b expected %b", n, {t0,b0,dn0}, ev);
      end
      if (n == 30)  begin s0 = 1'b1; d0 = ~w; end
      if (n == 31)  s0 = 1'b0;
      if (n == 100) d0 = $urandom;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    logic [2:0] ev;
    w = $urandom;
    exp_bits.delete();
    model_frame({32'h0, w}, 8, 4, 0, 2, 0);
    s0 = 1'b1; d0 = w;
    @(negedge clk);
    s0 = 1'b0;
    for (int n = 0; n < 98; n++) begin
      ev = {exp_bits[n/4], 2'b10};
      checks++;
      if ({t0,b0,dn0} !== ev) begin
        errors++;
        $display("FAIL pre-reset cycle %0d: got %b expected %b", n, {t0,b0,dn0}, ev);
      end
      @(negedge clk);
    end
    // Between edges: the reset must act without a clock.
    rst = 1'b1;
    #1;
    checks++;
    if ({t0,b0,dn0} !== 3'b100) begin
      errors++;
      $display("FAIL async reset mid-word: got %b expected 100", {t0,b0,dn0});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    w = $urandom;
    exp_bits.delete();
    model_frame({32'h0, w}, 8, 4, 0, 2, 0);
    s0 = 1'b1; d0 = w;
    @(negedge clk);
    s0 = 1'b0;
    for (int n = 0; n <= 177; n++) begin
      ev = (n < 176) ? {exp_bits[n/4], 2'b10} : (n == 176) ? 3'b101 : 3'b100;
      checks++;
      if ({t0,b0,dn0} !== ev) begin
        errors++;
        $display("FAIL post-reset word cycle %0d: got %b expected %b", n, {t0,b0,dn0}, ev);
      end
      @(negedge clk);
    end
  endtask

  // tx_start held high: three words chained with no idle bits, done every 24 clocks.
  task automatic test_back_to_back();
    logic [14:0] w [3];
    logic [2:0] ev;
    for (int i = 0; i < 3; i++) w[i] = 15'($urandom);
    exp_bits.delete();
    for (int i = 0; i < 3; i++) model_frame({49'h0, w[i]}, 5, 3, 2, 1, 0);
    s4 = 1'b1; d4 = w[0];
    @(negedge clk);
    d4 = w[1];
    for (int n = 0; n <= 73; n++) begin
      if (n < 72)       ev = {exp_bits[n], 1'b1, (n > 0 && n % 24 == 0)};
      else if (n == 72) ev = 3'b101;
      else              ev = 3'b100;
      checks++;
      if ({t4,b4,dn4} !== ev) begin
        errors++;
        $display("FAIL back-to-back cycle %0d: got %b expected %b", n, {t4,b4,dn4}, ev);
      end
      if (n == 24) d4 = w[2];
      if (n == 48) s4 = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic_words();
    test_parity();
    test_msb_first();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_word_tx.md
# uart_word_tx

Parametrised multi-byte UART transmitter, the successor to the fixed 4-byte/8N2 word transmitter. It accepts one word of `WORD_BYTES` bytes with a start/busy/done handshake and serialises the bytes back-to-back on `txd`. Frame format is configurable by parameter: data bits, parity, stop bits and byte order. A bit-period divider is built in, so no separate baud-tick generator is needed and the first bit is phase-aligned to the start request.

## Interface
- `CLK_DIV`, 434: clock cycles per bit period; legal range ≥1.
- `DATA_BITS`, 8: data bits per byte; legal range 5–8.
- `WORD_BYTES`, 4: bytes per word; legal range 1–8.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 2: 1 or 2.
- `MSB_BYTE_FIRST`, 0: 0 sends byte 0 (`tx_data[DATA_BITS-1:0]`) first; 1 sends the top byte first.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `tx_start`  in  1  request; sampled every cycle, honoured only when idle.
- `tx_data`  in  `WORD_BYTES*DATA_BITS`  word to send; sampled only on the accept edge.
- `tx_busy`  out  1  high from the accept edge until the word completes.
- `tx_done`  out  1  one-cycle pulse when the last stop bit of the last byte ends.
- `txd`  out  1  serial line; idle high; registered output.

## Operation
- States: IDLE, START, DATA, PAR, STOP.
- **IDLE:** `txd`=1 and `tx_busy`=0.
  - `tx_start`=1 accepts the request: latch `tx_data` into the shift register, clear the byte counter, load the divider, go to START.
- **START:** `txd`=0 for one bit period.
- **DATA:** `DATA_BITS` bits, LSB first, taken from the current byte.
- **PAR:** entered only if `PARITY`≠0.
  - Parity bit is the XOR of the data bits, inverted for odd parity.
  - Odd parity: total ones across data+parity is odd. Even parity: the total is even.
- **STOP:** `txd`=1 for `STOP_BITS` bit periods.
  - If bytes remain: select the next byte and go directly to START (no idle gap).
  - Else: go to IDLE, pulse `tx_done`, drop `tx_busy`.
- **Byte selection:** byte index advances 0…`WORD_BYTES`-1. `MSB_BYTE_FIRST`=1 reverses the order.
- **Divider:** counts `CLK_DIV`-1 down to 0. Each bit boundary occurs when the count is 0, and the counter then reloads.
- **Start while busy:** `tx_start` is ignored while `tx_busy`=1. `tx_data` changes are ignored after the accept edge.
- **Reset values (any time, including mid-frame):** `txd`=1, `tx_busy`=0, `tx_done`=0, state IDLE, all counters 0.
  - A partial frame is abandoned; the line returns high immediately.
  - The first `tx_start` after `rst` deasserts is accepted normally.
- **Counter widths:**
  - Divider: $clog2(`CLK_DIV`), minimum 1.
  - Bit counter: 3 bits.
  - Byte counter: $clog2(`WORD_BYTES`)+1.

## Timing
- Frame bits per byte: F = 1 + `DATA_BITS` + (`PARITY`≠0) + `STOP_BITS`.
- Accept edge is E0, the edge at which `tx_start`=1 is seen in IDLE.
  - At E0: `txd`←0 and `tx_busy`←1 (visible after E0).
  - Bit k of the word stream, counted from 0 across all bytes, starts at edge E0 + k·`CLK_DIV`.
- Completion edge is E0 + `WORD_BYTES`·F·`CLK_DIV`. At that edge:
  - `tx_busy`←0 and `tx_done`←1.
  - `tx_done` clears at the following edge.
- **Back-to-back words:** `tx_start` held high in the cycle `tx_done`=1 is accepted at that cycle's edge.
  - The next start bit immediately follows the last stop bit; the line is never high for extra cycles.
- **`CLK_DIV`=1:** one bit per clock; the same equations hold.
- **Latency:** request to first start-bit edge is 1 clock.

## Test plan
- `CLK_DIV`=4, 8 data bits, no parity, 2 stop bits, 4 bytes; `tx_data`=0x44332211.
  - → `txd` carries bytes 0x11, 0x22, 0x33, 0x44, each as 0 + LSB-first data + 11, 44 clocks per byte.
  - → `tx_done` pulses exactly 176 clocks after accept; `tx_busy` is high 176 cycles.
- `PARITY`=2, `WORD_BYTES`=1, `STOP_BITS`=1, data 0x07 → parity bit 1, frame 0,1,1,1,0,0,0,0,0,1,1. With `PARITY`=1 the parity bit is 0.
- `MSB_BYTE_FIRST`=1, `tx_data`=0x44332211 → byte order 0x44, 0x33, 0x22, 0x11.
- Second `tx_start` pulse and a `tx_data` change mid-word → both ignored; output identical to the single-request case.
- `rst` asserted mid-byte-2 → `txd`=1, `tx_busy`=0 immediately, with no clock needed; a new request after release sends a clean full word.
- `tx_start` held high continuously, `CLK_DIV`=1, `DATA_BITS`=5 → consecutive words with no idle bits between them; `tx_done` pulses every `WORD_BYTES`·F clocks.
